cordic_rr_scheduler: RTL and testbench
======================================

Name: cordic_rr_scheduler

Overview:
- Round-robin scheduler that shares one iterative CORDIC_sin_cos engine between NREQ independent requesters.
- Captures a requester's angle, drives the core's edge-triggered strobe and waits for the core's completion pulse.
- Returns cos/sin to the granted requester with a done pulse.
- Sits between the core and the phase generators or modulators that need sin/cos. A watchdog and a post-reset drain keep it safe, because the core itself has no reset.

Parameters:
- NREQ, 4, number of requesters (2..8).
- XY_SZ, 16, core data width; result ports are XY_SZ+1 bits.
- TIMEOUT, 64, maximum cycles in WAIT before abort.
- DRAIN, XY_SZ+4, idle cycles after reset or abort before the first grant.

Ports:
- clock  in  1  single system clock, all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request level; held high until ack.
- angle_in  in  32*NREQ  requester i's angle in bits [32i+31:32i]; full-scale signed turn, 0x40000000 = +90°.
- ack  out  NREQ  one-cycle pulse; angle_in slice captured this cycle.
- done  out  NREQ  one-cycle pulse; cos_out/sin_out valid for that requester.
- cos_out  out  XY_SZ+1  registered cosine result.
- sin_out  out  XY_SZ+1  registered sine result.
- busy  out  1  high in any state other than IDLE.
- error  out  1  sticky timeout flag.
- core_strobe  out  1  to core strobe_in.
- core_angle  out  32  to core angle; registered, stable from grant until the next grant.
- core_strobe_out  in  1  core completion pulse.
- core_cos  in  XY_SZ+1  core cos.
- core_sin  in  XY_SZ+1  core sin.

Behaviour:
- Reset values: ack=0, done=0, cos_out=0, sin_out=0, core_strobe=0, core_angle=0, error=0, busy=1, rr pointer=0, state=DRAIN, drain counter=DRAIN.
- Reset applies in any state, including mid-computation. No done is issued for the aborted job, and core_strobe_out is ignored until DRAIN completes.
- DRAIN state:
  - core_strobe=0; counter decrements each cycle.
  - Go to IDLE when the counter reaches 0.
  - A core_strobe_out seen here is discarded.
- IDLE state (busy=0):
  - If any req is high, grant the lowest index at or after the rr pointer, wrapping modulo NREQ.
  - In the same cycle: ack[g]=1, core_angle <= angle_in[g], grant index latched, pointer <= (g+1) mod NREQ. Next state is STROBE.
  - If no req is high, stay in IDLE.
- STROBE state: core_strobe=1 for exactly one cycle; next state is WAIT.
- WAIT state:
  - core_strobe=0; watchdog counts from 0.
  - When core_strobe_out is sampled high: cos_out <= core_cos, sin_out <= core_sin, done[g]=1 on the following cycle, and state returns to IDLE in that same cycle.
  - If the watchdog reaches TIMEOUT first: error <= 1 (sticky until reset), done[g]=1 with cos_out/sin_out unchanged, then go to DRAIN with counter=DRAIN.
- Latency: ack to done is core latency + 2 cycles (nominally XY_SZ+3 with the real core). Correctness must not depend on the exact core latency.
- Back-to-back operation:
  - A new grant may occur in the same cycle done is asserted, because IDLE is active.
  - core_strobe is low for at least TIMEOUT-bounded WAIT cycles between pulses, so the core always sees a fresh rising edge.
- Request rules:
  - A req dropped before ack is a withdrawal; no state change.
  - A req held after done requests a new job.
  - ack and done are never both asserted for the same index in one cycle.
  - At most one bit of ack, and one bit of done, is high per cycle.
- core_angle is not changed while busy, except by a new grant.

Test Plan:
- Single job: req[0]=1, angle 0x00000000 -> ack[0] one cycle; done[0] within XY_SZ+4 cycles; cos_out 32000±8, sin_out 0±8.
- Quadrant check: req[1] with angle 0x40000000 -> done[1]; cos_out 0±8, sin_out 32000±8. Repeat with 0xC0000000 -> sin_out -32000±8.
- Contention: req=4'b1111 held continuously from reset -> ack order 0,1,2,3,0,…; each done matches the preceding ack index; exactly one ack and one done per job.
- Fairness: req[0] and req[2] held high, pointer=1 -> grants alternate 2,0,2,0; req[3] raised mid-run is granted within two jobs.
- Reset mid-WAIT: assert reset for 1 cycle, 5 cycles after STROBE -> no done for the aborted job; core_strobe stays 0 for DRAIN cycles; first new ack no earlier than DRAIN+1 cycles after reset deasserts.
- Timeout: model core that never pulses core_strobe_out -> error=1 and done[g] exactly TIMEOUT+1 cycles after STROBE; busy through DRAIN; error stays 1 across subsequent good jobs until reset.

Source files
------------

// File: rtl/cordic_rr_scheduler.sv
// Round-robin scheduler sharing one iterative sin/cos CORDIC core between NREQ requesters.
// The core has no reset, so a drain window and a WAIT watchdog keep stale completions out.
module cordic_rr_scheduler #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned XY_SZ   = 16,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned DRAIN   = XY_SZ + 4
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic [NREQ-1:0]      req_i,
    input  logic [32*NREQ-1:0]   angle_in_i,
    output logic [NREQ-1:0]      ack_o,
    output logic [NREQ-1:0]      done_o,
    output logic [XY_SZ:0]       cos_out_o,
    output logic [XY_SZ:0]       sin_out_o,
    output logic                 busy_o,
    output logic                 error_o,
    output logic                 core_strobe_o,
    output logic [31:0]          core_angle_o,
    input  logic                 core_strobe_out_i,
    input  logic [XY_SZ:0]       core_cos_i,
    input  logic [XY_SZ:0]       core_sin_i
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned DW = $clog2(DRAIN + 1);
    localparam int unsigned WW = $clog2(TIMEOUT + 1);
    localparam int unsigned RW = XY_SZ + 1;
    localparam int unsigned AW = 32;

    typedef enum logic [1:0] {
        S_DRAIN  = 2'd0,
        S_IDLE   = 2'd1,
        S_STROBE = 2'd2,
        S_WAIT   = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic [WW-1:0]   wd_q, wd_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic [AW-1:0]   angle_q, angle_d;
    logic [RW-1:0]   cos_q, cos_d;
    logic [RW-1:0]   sin_q, sin_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            error_q, error_d;
    logic            strobe_q, strobe_d;
    logic            busy_q, busy_d;

    logic [AW-1:0]   angle_arr [NREQ];
    logic [NREQ-1:0] req_elig;
    logic            gnt_vld;
    logic [IW-1:0]   gnt_idx;
    logic [IW:0]     cand;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_angle
        assign angle_arr[gi] = angle_in_i[AW*gi +: AW];
    end

    // Rotating-priority pick; the index finishing this cycle is skipped so ack and done never coincide.
    always_comb begin
        req_elig = req_i & ~done_q;
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        cand     = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if (!gnt_vld && req_elig[cand[IW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand[IW-1:0];
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= S_DRAIN;
            drain_q  <= DW'(DRAIN);
            wd_q     <= '0;
            ptr_q    <= '0;
            gnt_q    <= '0;
            angle_q  <= '0;
            cos_q    <= '0;
            sin_q    <= '0;
            done_q   <= '0;
            error_q  <= 1'b0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            wd_q     <= wd_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            angle_q  <= angle_d;
            cos_q    <= cos_d;
            sin_q    <= sin_d;
            done_q   <= done_d;
            error_q  <= error_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        wd_d    = wd_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        angle_d = angle_q;
        cos_d   = cos_q;
        sin_d   = sin_q;
        error_d = error_q;
        done_d  = '0;
        ack_o   = '0;

        unique case (state_q)
            // Completions arriving here belong to an abandoned job and are dropped.
            S_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            S_IDLE: begin
                if (gnt_vld) begin
                    ack_o[gnt_idx] = 1'b1;
                    angle_d        = angle_arr[gnt_idx];
                    gnt_d          = gnt_idx;
                    ptr_d          = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
                    state_d        = S_STROBE;
                end
            end
            S_STROBE: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (core_strobe_out_i) begin
                    cos_d         = core_cos_i;
                    sin_d         = core_sin_i;
                    done_d[gnt_q] = 1'b1;
                    state_d       = S_IDLE;
                end else if (wd_q == WW'(TIMEOUT - 1)) begin
                    error_d       = 1'b1;
                    done_d[gnt_q] = 1'b1;
                    drain_d       = DW'(DRAIN);
                    state_d       = S_DRAIN;
                end else begin
                    wd_d = wd_q + WW'(1);
                end
            end
            default: begin
                drain_d = DW'(DRAIN);
                state_d = S_DRAIN;
            end
        endcase

        strobe_d = (state_d == S_STROBE);
        busy_d   = (state_d != S_IDLE);
    end

    assign done_o        = done_q;
    assign cos_out_o     = cos_q;
    assign sin_out_o     = sin_q;
    assign busy_o        = busy_q;
    assign error_o       = error_q;
    assign core_strobe_o = strobe_q;
    assign core_angle_o  = angle_q;

endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// Scoreboard bench for cordic_rr_scheduler with a behavioural stand-in for the CORDIC core.
module tb_cordic_rr_scheduler;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned XY_SZ   = 16;
    localparam int unsigned TIMEOUT = 64;
    localparam int unsigned DRAIN   = XY_SZ + 4;
    localparam int unsigned RW      = XY_SZ + 1;
    localparam int          BOUND   = 400;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [32*NREQ-1:0] angle_in = '0;
    logic [NREQ-1:0]   ack, done;
    logic [RW-1:0]     cos_out, sin_out;
    logic              busy, error, core_strobe;
    logic [31:0]       core_angle;
    logic              core_so = 1'b0;
    logic [RW-1:0]     core_cos = '0, core_sin = '0;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit core_hang = 1'b0;

    cordic_rr_scheduler #(
        .NREQ(NREQ), .XY_SZ(XY_SZ), .TIMEOUT(TIMEOUT), .DRAIN(DRAIN)
    ) dut (
        .clock_i          (clock),
        .reset_i          (reset),
        .req_i            (req),
        .angle_in_i       (angle_in),
        .ack_o            (ack),
        .done_o           (done),
        .cos_out_o        (cos_out),
        .sin_out_o        (sin_out),
        .busy_o           (busy),
        .error_o          (error),
        .core_strobe_o    (core_strobe),
        .core_angle_o     (core_angle),
        .core_strobe_out_i(core_so),
        .core_cos_i       (core_cos),
        .core_sin_i       (core_sin)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [RW-1:0] trig(input logic [31:0] a, input bit want_sin);
        real th, v;
        int  r;
        th = $itor($signed(a)) * 3.14159265358979 / 2147483648.0;
        v  = want_sin ? 32000.0 * $sin(th) : 32000.0 * $cos(th);
        r  = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
        return RW'(r);
    endfunction

    // Core stand-in: rising strobe launches a job, completion pulse XY_SZ+1 edges later; no reset.
    logic strobe_prev = 1'b0;
    int   lat_cnt = 0;
    always @(posedge clock) begin
        strobe_prev <= core_strobe;
        core_so     <= (lat_cnt == 1);
        if (core_strobe && !strobe_prev) begin
            core_cos <= trig(core_angle, 1'b0);
            core_sin <= trig(core_angle, 1'b1);
            lat_cnt  <= core_hang ? 0 : int'(XY_SZ);
        end else if (lat_cnt != 0) begin
            lat_cnt <= lat_cnt - 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    typedef struct {
        int            idx;
        logic [RW-1:0] c;
        logic [RW-1:0] s;
        bit            hang;
        int            t;
    } job_t;

    job_t          sb[$];
    int            ack_log[$];
    int            ack_t[$];
    logic [RW-1:0] last_cos = '0;
    logic [RW-1:0] last_sin = '0;

    always @(negedge clock) begin
        job_t j;
        if (reset) begin
            sb.delete();
            ack_log.delete();
            ack_t.delete();
            last_cos = '0;
            last_sin = '0;
        end else begin
            if (done != '0) begin
                check("done_onehot", 64'($countones(done)), 64'd1);
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'd0);
                end else begin
                    j = sb.pop_front();
                    check("done_idx", 64'(done), 64'(1) << j.idx);
                    if (j.hang) begin
                        check("timeout_cos_held", 64'(cos_out), 64'(last_cos));
                        check("timeout_sin_held", 64'(sin_out), 64'(last_sin));
                        check("timeout_error", 64'(error), 64'd1);
                        check("timeout_latency", 64'(cyc - j.t), 64'(TIMEOUT + 2));
                    end else begin
                        check("cos_out", 64'(cos_out), 64'(j.c));
                        check("sin_out", 64'(sin_out), 64'(j.s));
                        check("latency_bound", 64'((cyc - j.t) <= int'(XY_SZ + 4)), 64'd1);
                        last_cos = j.c;
                        last_sin = j.s;
                    end
                end
            end
            if (ack != '0) begin
                check("ack_onehot", 64'($countones(ack)), 64'd1);
                check("ack_without_req", 64'(ack & ~req), 64'd0);
                check("ack_done_same_idx", 64'(ack & done), 64'd0);
                for (int i = 0; i < NREQ; i++) begin
                    if (ack[i]) begin
                        j.idx  = i;
                        j.c    = trig(angle_in[32*i +: 32], 1'b0);
                        j.s    = trig(angle_in[32*i +: 32], 1'b1);
                        j.hang = core_hang;
                        j.t    = cyc;
                        sb.push_back(j);
                        ack_log.push_back(i);
                        ack_t.push_back(cyc);
                    end
                end
            end
        end
    end

    task automatic wait_acks(input int n);
        for (int k = 0; k < BOUND * n && ack_log.size() < n; k++) begin
            @(negedge clock);
            #1;
        end
        check("acks_seen", 64'(ack_log.size() >= n), 64'd1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int k = 0; k < BOUND && !ok; k++) begin
            @(negedge clock);
            #1;
            ok = (sb.size() == 0) && !busy;
        end
        check("idle_reached", 64'(ok), 64'd1);
    endtask

    task automatic issue(input int i, input logic [31:0] a);
        int n0;
        @(posedge clock);
        #1;
        angle_in[32*i +: 32] = a;
        req[i] = 1'b1;
        n0 = ack_log.size();
        for (int k = 0; k < BOUND && ack_log.size() <= n0; k++) begin
            @(negedge clock);
            #1;
        end
        check("issue_acked", 64'(ack_log.size() > n0), 64'd1);
        @(posedge clock);
        #1;
        req[i] = 1'b0;
    endtask

    initial begin
        int            rel;
        int            hi;
        bit            ok;
        int            exp_fair [6] = '{2, 0, 2, 3, 0, 2};
        logic [RW-1:0] fs_pos, fs_neg;
        fs_pos = RW'(32000);
        fs_neg = RW'(-32000);

        // Reset values, with all four requesters already asking
        for (int i = 0; i < NREQ; i++) angle_in[32*i +: 32] = 32'(i + 1) << 28;
        req = '1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_cos", 64'(cos_out), 64'd0);
        check("rst_sin", 64'(sin_out), 64'd0);
        check("rst_core_strobe", 64'(core_strobe), 64'd0);
        check("rst_core_angle", 64'(core_angle), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_busy", 64'(busy), 64'd1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        rel = cyc;

        // Contention from reset: strict rotation 0,1,2,3,0,...
        wait_acks(8);
        @(posedge clock);
        #1;
        req = '0;
        if (ack_t.size() > 0)
            check("drain_before_first_ack", 64'((ack_t[0] - rel) >= int'(DRAIN + 1)), 64'd1);
        for (int i = 0; i < 8 && i < ack_log.size(); i++)
            check("contention_order", 64'(ack_log[i]), 64'(i % 4));
        wait_idle();

        // Single jobs and quadrants
        issue(0, 32'h0000_0000);
        wait_idle();
        check("zero_cos", 64'(cos_out), 64'(fs_pos));
        issue(1, 32'h4000_0000);
        wait_idle();
        check("q90_sin", 64'(sin_out), 64'(fs_pos));
        check("q90_cos", 64'(cos_out), 64'd0);
        issue(1, 32'hC000_0000);
        wait_idle();
        check("q270_sin", 64'(sin_out), 64'(fs_neg));
        for (int k = 0; k < 4; k++) begin
            issue(int'($urandom_range(0, NREQ - 1)), 32'($urandom));
            wait_idle();
        end

        // Fairness: pointer parked at 1, then req[0]/req[2] held, req[3] joins later
        issue(0, 32'h0100_0000);
        wait_idle();
        @(posedge clock);
        #1;
        ack_log.delete();
        angle_in[0 +: 32]  = 32'h1111_0000;
        angle_in[64 +: 32] = 32'h2222_0000;
        angle_in[96 +: 32] = 32'h3333_0000;
        req[0] = 1'b1;
        req[2] = 1'b1;
        wait_acks(2);
        @(posedge clock);
        #1;
        req[3] = 1'b1;
        wait_acks(6);
        @(posedge clock);
        #1;
        req = '0;
        for (int i = 0; i < 6 && i < ack_log.size(); i++)
            check("fair_order", 64'(ack_log[i]), 64'(exp_fair[i]));
        wait_idle();

        // Reset while the core is mid-computation
        issue(2, 32'h2000_0000);
        ok = 1'b0;
        for (int k = 0; k < BOUND && !ok; k++) begin
            @(negedge clock);
            ok = core_strobe;
        end
        check("strobe_seen", 64'(ok), 64'd1);
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        rel = cyc;
        angle_in[96 +: 32] = 32'h1000_0000;
        req[3] = 1'b1;
        hi = 0;
        repeat (DRAIN) begin
            @(negedge clock);
            if (core_strobe) hi++;
        end
        check("drain_strobe_low", 64'(hi), 64'd0);
        wait_acks(1);
        @(posedge clock);
        #1;
        req = '0;
        if (ack_t.size() > 0)
            check("reset_drain_first_ack", 64'((ack_t[0] - rel) >= int'(DRAIN + 1)), 64'd1);
        wait_idle();
        check("no_error_after_reset", 64'(error), 64'd0);

        // Watchdog: core never completes
        core_hang = 1'b1;
        issue(1, 32'h1234_5678);
        ok = 1'b0;
        for (int k = 0; k < BOUND && !ok; k++) begin
            @(negedge clock);
            #1;
            ok = (sb.size() == 0);
        end
        check("timeout_done_seen", 64'(ok), 64'd1);
        hi = 0;
        repeat (DRAIN) begin
            @(negedge clock);
            if (!busy) hi++;
        end
        check("busy_through_drain", 64'(hi), 64'd0);
        core_hang = 1'b0;
        issue(2, 32'h0800_0000);
        wait_idle();
        check("error_sticky_1", 64'(error), 64'd1);
        issue(3, 32'h7000_0000);
        wait_idle();
        check("error_sticky_2", 64'(error), 64'd1);

        // Only reset clears the error flag
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("error_cleared", 64'(error), 64'd0);
        check("busy_in_reset", 64'(busy), 64'd1);
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
